// File: rtl/button_event_pkg.sv
// Shared types and default limits for the button gesture path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package button_event_pkg;

    // Gesture codes as seen by the consumer on o_Event_Code.
    typedef enum logic [1:0] {
        EVT_SHORT        = 2'd0,
        EVT_DOUBLE       = 2'd1,
        EVT_LONG         = 2'd2,
        EVT_LONG_RELEASE = 2'd3
    } event_code_t;

    // Gesture classifier states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_GAP       = 3'd3,
        ST_WAIT_REL  = 3'd4
    } gesture_state_t;

    // Defaults assume a 25 MHz clock: 10 ms debounce, 1 s long press, 300 ms click gap.
    localparam int unsigned DEF_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned DEF_LONG_LIMIT     = 25000000;
    localparam int unsigned DEF_GAP_LIMIT      = 7500000;

    // Used to size the timer shared by the long-press and click-gap measurements.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_core.sv
// Synchronises the raw button and only follows it after it has been stable for LIMIT cycles.
// Latency: o_Level changes LIMIT+3 cycles after a clean raw edge (2 sync + LIMIT+1 counting).
// Backpressure: none; free-running, any glitch restarts the stability window.
module button_debounce_core
    import button_event_pkg::*;
#(
    parameter int unsigned c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Button,
    output logic o_Level
);

    localparam int unsigned          CNT_W   = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(c_DEBOUNCE_LIMIT);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser, then count how long the synced input has disagreed with the level.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_Button;
            sync2_q <= sync1_q;
            if ((sync2_q != level_q) && (cnt_q < CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if ((sync2_q != level_q) && (cnt_q == CNT_MAX)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_Level = level_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies the debounced button into SHORT/DOUBLE/LONG/LONG_RELEASE gestures.
// Latency: event valid one cycle after the classifier decides; DOUBLE one cycle after the second rise.
// Backpressure: single-entry valid/ack register; an event arriving while one is pending and unacked is dropped with an o_Overrun pulse.
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int unsigned c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned c_LONG_LIMIT     = DEF_LONG_LIMIT,
    parameter int unsigned c_GAP_LIMIT      = DEF_GAP_LIMIT
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Button,
    input  logic       i_Ack,
    output logic       o_Event_Valid,
    output logic [1:0] o_Event_Code,
    output logic       o_Overrun,
    output logic       o_Level
);

    localparam int unsigned      TMR_LIMIT = max_u(c_LONG_LIMIT, c_GAP_LIMIT);
    localparam int unsigned      TMR_W     = $clog2(TMR_LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TMR_LIMIT);
    localparam logic [TMR_W-1:0] LONG_T    = TMR_W'(c_LONG_LIMIT);
    localparam logic [TMR_W-1:0] GAP_T     = TMR_W'(c_GAP_LIMIT);

    logic           level_w;
    logic           level_prev_q;
    logic           rise_q;
    logic           fall_q;

    gesture_state_t state_q;
    logic [TMR_W-1:0] timer_q;

    logic           emit_vld;
    event_code_t    emit_code;

    logic           valid_q, valid_d;
    event_code_t    code_q, code_d;
    logic           overrun_q, overrun_d;

    button_debounce_core #(
        .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Button (i_Button),
        .o_Level  (level_w)
    );

    // Registered edge pulses of the debounced level; the classifier sees nothing else.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            level_prev_q <= level_w;
            rise_q       <= level_w & ~level_prev_q;
            fall_q       <= ~level_w & level_prev_q;
        end
    end

    // Gesture state and the shared timer, which restarts on every state entry and saturates.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            if (timer_q != TMR_MAX) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        state_q <= ST_PRESS1;
                        timer_q <= '0;
                    end
                end
                ST_PRESS1: begin
                    // A release in the same cycle as expiry counts as a click, not a long press.
                    if (fall_q) begin
                        state_q <= ST_GAP;
                        timer_q <= '0;
                    end else if (timer_q == LONG_T) begin
                        state_q <= ST_LONG_HELD;
                        timer_q <= '0;
                    end
                end
                ST_LONG_HELD: begin
                    if (fall_q) begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                end
                ST_GAP: begin
                    // A second press in the same cycle as gap expiry still makes a double click.
                    if (rise_q) begin
                        state_q <= ST_WAIT_REL;
                        timer_q <= '0;
                    end else if (timer_q == GAP_T) begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                end
                ST_WAIT_REL: begin
                    if (fall_q) begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Events produced by the state transitions above, with the same edge-over-timer priority.
    always_comb begin
        emit_vld  = 1'b0;
        emit_code = EVT_SHORT;
        case (state_q)
            ST_PRESS1: begin
                if (!fall_q && (timer_q == LONG_T)) begin
                    emit_vld  = 1'b1;
                    emit_code = EVT_LONG;
                end
            end
            ST_LONG_HELD: begin
                if (fall_q) begin
                    emit_vld  = 1'b1;
                    emit_code = EVT_LONG_RELEASE;
                end
            end
            ST_GAP: begin
                if (rise_q) begin
                    emit_vld  = 1'b1;
                    emit_code = EVT_DOUBLE;
                end else if (timer_q == GAP_T) begin
                    emit_vld  = 1'b1;
                    emit_code = EVT_SHORT;
                end
            end
            default: ;
        endcase
    end

    // Single-entry event slot: an ack frees it in the same cycle a new event may load.
    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = 1'b0;
        if (emit_vld) begin
            if (!valid_q || i_Ack) begin
                valid_d = 1'b1;
                code_d  = emit_code;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_Ack) begin
            valid_d = 1'b0;
        end
    end

    // Event slot registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_q   <= 1'b0;
            code_q    <= EVT_SHORT;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_Event_Valid = valid_q;
    assign o_Event_Code  = code_q;
    assign o_Overrun     = overrun_q;
    assign o_Level       = level_w;

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Sequences the button-debounce path. A raw mechanical button is synchronised and debounced, and the clean level is classified into user gestures: single click, double click, long press and long-press release. Events are delivered through a single-entry valid/ack register to the downstream consumer, a UI or menu FSM. The block sits between the board button pin and application logic, so consumers never count milliseconds themselves.

## Interface
- `c_DEBOUNCE_LIMIT`, default 250000: stable cycles required before the debounced level changes (10 ms at 25 MHz).
- `c_LONG_LIMIT`, default 25000000: held cycles, measured from the debounced press, that qualify a long press (1 s).
- `c_GAP_LIMIT`, default 7500000: maximum release gap, in cycles, between clicks of a double click (300 ms).
- `i_Clk`, input, 1: system clock. One clock domain only.
- `i_Rst_n`, input, 1: reset. Asynchronous, active-low.
- `i_Button`, input, 1: raw button, asynchronous to `i_Clk`, 1 = pressed.
- `i_Ack`, input, 1: consumer accepts the pending event.
- `o_Event_Valid`, output, 1: event pending. Reset 0.
- `o_Event_Code`, output, 2: 0 = SHORT, 1 = DOUBLE, 2 = LONG, 3 = LONG_RELEASE. Reset 0.
- `o_Overrun`, output, 1: one-cycle pulse when an event is dropped. Reset 0.
- `o_Level`, output, 1: debounced button level. Reset 0.

## Operation
- Input stage: a 2-flop synchroniser feeds a stable counter. While the synced input ≠ `o_Level` and count < LIMIT, count increments. At count == LIMIT, `o_Level` takes the synced input and count clears. Any other condition clears count, so a glitch restarts the window.
- The gesture FSM runs on debounced edges only (`rise`/`fall` = registered `o_Level` transitions). A single timer is shared across states, cleared on every state entry, and saturates at its max.
- FSM states and transitions:
  - IDLE: `rise` → PRESS1.
  - PRESS1: timer == LONG_LIMIT → emit LONG, go to LONG_HELD. `fall` → GAP.
  - LONG_HELD: `fall` → emit LONG_RELEASE, go to IDLE.
  - GAP: `rise` → emit DOUBLE, go to WAIT_REL. Timer == GAP_LIMIT → emit SHORT, go to IDLE.
  - WAIT_REL: `fall` → IDLE. No long detection here.
- Simultaneous timer expiry and edge in the same cycle: the edge wins. PRESS1 goes to GAP, and GAP goes to WAIT_REL with DOUBLE.
- Event register behaviour:
  - An emit with valid = 0 loads the code and sets valid.
  - Valid & ack clears valid, unless an emit occurs in the same cycle. In that case the new code loads and valid stays 1.
  - An emit with valid = 1 and no ack drops the new event, keeps the old code and pulses `o_Overrun`.
- Reset asserted mid-gesture: all state, counters and outputs return to reset values immediately. No event is emitted on reset release, even if the button is held. The next gesture starts only after a debounced `rise`.
- Counter widths are $clog2(LIMIT+1) per counter. The shared timer is sized for max(LONG, GAP).

## Timing
- `o_Level` changes exactly LIMIT+3 cycles after a clean raw edge: 2 synchroniser cycles plus LIMIT+1 counting cycles.
- `rise`/`fall` are asserted one cycle after the `o_Level` change.
- `o_Event_Valid` rises one cycle after the FSM emit condition.
- LONG: valid rises LONG_LIMIT+2 cycles after `rise`.
- SHORT: valid rises GAP_LIMIT+2 cycles after `fall`.
- DOUBLE: valid rises one cycle after the second `rise`.
- The consumer may hold `i_Ack` high permanently. Each event is then valid for exactly one cycle.
- `i_Ack` while valid = 0 is ignored.

## Structure
- Package `button_event_pkg` holds:
  - the event-code enum (SHORT/DOUBLE/LONG/LONG_RELEASE);
  - the FSM state enum (IDLE, PRESS1, LONG_HELD, GAP, WAIT_REL);
  - default limit constants.
- Sub-module `button_debounce_core` contains the synchroniser and stable counter. It takes `c_DEBOUNCE_LIMIT` and outputs the level.
- The top level holds edge detection, the FSM, the shared timer and the event register.

## Test plan
All scenarios use DEBOUNCE = 4, LONG = 20, GAP = 10.
- Reset values: hold `i_Rst_n` = 0 with `i_Button` = 1, then release → all outputs 0. After release, `o_Level` rises 7 cycles later and no event appears during that time.
- Bounce rejection: toggle `i_Button` every 3 cycles for 40 cycles → `o_Level` stays 0. Then hold it at 1 → `o_Level` = 1 after 7 cycles.
- Single click: press for 10 debounced cycles, then release → SHORT (code 0) valid 12 cycles after `fall`. No other event.
- Double click: press 5, release 5, press → DOUBLE (code 1) one cycle after the second `rise`. Releasing afterwards emits nothing.
- Long press: hold for 30 cycles → LONG (code 2) 22 cycles after `rise`. Release → LONG_RELEASE (code 3).
- Handshake: hold `i_Ack` = 0 through LONG then LONG_RELEASE → `o_Overrun` pulses once and the code stays 2. Repeat with `i_Ack` tied to 1 → each valid pulse lasts one cycle and `o_Overrun` never asserts.
